mac_result_drain: RTL and testbench
===================================

// Module: mac_result_drain
// PURPOSE
//  Downstream consumer of the 8-lane MAC array result bank.
//  - Captures all eight DATA_W-bit lane results in one valid/ready handshake.
//  - Serialises them lane 0..7 onto a single-word valid/ready stream, tagged per frame.
//  - Feeds the result write-back path and lets the array run ahead by one frame.
// PARAMETERS
//  DATA_W  16  width of each lane result and of out_data
//  TAG_W   4   width of frame tag counter; wraps modulo 2**TAG_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       lane bank mac_in0..7 holds a complete result set
//  in_ready   out  1       drain accepts a result set this cycle
//  mac_in0..7 in   DATA_W  lane results 0..7; sampled only on in_valid&&in_ready
//  out_valid  out  1       out_data/out_lane/out_last/out_tag valid
//  out_ready  in   1       downstream accepts current beat
//  out_data   out  DATA_W  lane result (or sum word, see CONFIGURATION)
//  out_lane   out  4       beat index: 0..7 lanes; 8 = sum beat
//  out_last   out  1       final beat of frame
//  out_tag    out  TAG_W   tag of frame being drained
// BEHAVIOUR
//  - Reset (rst_n low, async):
//    - state=IDLE; out_valid, out_data, out_lane, out_last, out_tag = 0; shadow regs = 0.
//    - in_ready forced 0 while rst_n low.
//    - Mid-frame reset discards the frame: no further beats, tag restarts at 0.
//  - FSM states: IDLE, DRAIN, SUM (SUM exists only with the macro).
//  - IDLE: in_ready=1, out_valid=0.
//    - On in_valid&&in_ready: latch mac_in0..7 into shadow, lane_idx=0 -> DRAIN next cycle.
//    - Capture-to-first-beat latency: 1 cycle.
//  - DRAIN: out_valid=1, out_data=shadow[lane_idx], out_lane=lane_idx.
//    - On handshake with lane_idx<7: lane_idx++.
//    - On handshake with lane_idx==7: -> SUM if enabled, else frame complete.
//  - Frame complete: out_tag increments (wraps 2**TAG_W-1 -> 0); state -> IDLE.
//  - out_last=1 only on the final beat of the frame (lane 7, or sum beat if enabled).
//  - Back-to-back capture:
//    - in_ready = IDLE | (final beat present && out_ready), combinational on out_ready.
//    - Capture plus final-beat handshake in the same cycle: new frame's lane 0 appears
//      next cycle, tag already incremented. Zero bubble.
//  - Stall: while out_valid&&!out_ready, all out_* hold stable; out_valid never drops
//    without a handshake.
//  - in_valid is ignored outside in_ready; mac_inN is never resampled mid-frame.
// CONFIGURATION
//  MAC_DRAIN_SUM_EN defined:
//    - After lane 7, SUM emits one extra beat: out_lane=8, out_last=1.
//    - out_data = sum of 8 lanes, computed at DATA_W+3 bits and saturated to
//      2**DATA_W-1 if it overflows DATA_W.
//    - Sum is registered at capture, so the SUM beat adds no latency.
//  MAC_DRAIN_SUM_EN undefined: SUM state, sum logic and out_lane value 8 are absent;
//    frames are 8 beats, out_last on lane 7.
// TESTING
//  1 Reset: rst_n=0 -> all out_* 0, in_ready=0. Release -> in_ready=1 next edge, out_valid=0.
//  2 Basic frame, lanes 2,4,..,16, out_ready=1:
//    - 8 beats, data 0x0002..0x0010, lanes 0..7, out_last on lane 7, tag 0.
//    - With SUM_EN: ninth beat lane 8, data 0x0048.
//  3 Stall: drop out_ready for 3 cycles at lane 3 -> lane 3 data/tag held; no beat lost or duplicated.
//  4 Back-to-back: in_valid held high with a second set 0x1111..0x8888 ->
//    - captured on final-beat cycle; next cycle lane 0 = 0x1111, tag=1, no idle cycle.
//  5 Saturation (SUM_EN): all lanes 0xFFFF -> sum beat 0xFFFF; lanes 0x2000 -> 0xFFFF
//    (0x10000 overflows DATA_W); lanes 0x1000 -> 0x8000.
//  6 Wrap and mid-frame reset:
//    - 16 frames -> tag sequence 0..15 then 0.
//    - rst_n pulse at lane 5 -> out_valid=0 immediately, tag=0, next frame starts lane 0.

Source files
------------

// File: rtl/mac_result_drain.sv
// mac_result_drain: captures the 8-lane MAC result bank and streams it one lane per beat with a frame tag.
// Optional MAC_DRAIN_SUM_EN appends a saturated sum-of-lanes beat (out_lane 8) to every frame.
module mac_result_drain #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mac_in0,
  input  logic [DATA_W-1:0] mac_in1,
  input  logic [DATA_W-1:0] mac_in2,
  input  logic [DATA_W-1:0] mac_in3,
  input  logic [DATA_W-1:0] mac_in4,
  input  logic [DATA_W-1:0] mac_in5,
  input  logic [DATA_W-1:0] mac_in6,
  input  logic [DATA_W-1:0] mac_in7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_lane,
  output logic              out_last,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
`ifdef MAC_DRAIN_SUM_EN
  localparam logic [1:0] SUM   = 2'd2;
`endif

  logic [1:0]        state;
  logic [2:0]        lane_idx;
  logic [DATA_W-1:0] shadow [8];
  logic [DATA_W-1:0] lanes_in [8];
  logic              capture;
  logic              fire;
  logic              final_beat;

  always_comb begin
    lanes_in[0] = mac_in0;
    lanes_in[1] = mac_in1;
    lanes_in[2] = mac_in2;
    lanes_in[3] = mac_in3;
    lanes_in[4] = mac_in4;
    lanes_in[5] = mac_in5;
    lanes_in[6] = mac_in6;
    lanes_in[7] = mac_in7;
  end

`ifdef MAC_DRAIN_SUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W+2:0] sum_wide;
  logic [DATA_W-1:0] sum_sat;

  // Eight DATA_W addends need three guard bits; any carry into them saturates.
  always_comb begin
    sum_wide = '0;
    for (int i = 0; i < 8; i++) begin
      sum_wide = sum_wide + {3'b000, lanes_in[i]};
    end
    sum_sat = (sum_wide[DATA_W+2:DATA_W] != 3'b000) ? '1 : sum_wide[DATA_W-1:0];
  end

  assign final_beat = (state == SUM);
`else
  assign final_beat = (state == DRAIN) && (lane_idx == 3'd7);
`endif

  assign out_valid = (state != IDLE);
  assign out_last  = final_beat;
  assign fire      = out_valid && out_ready;
  // Accepting on the final handshake lets the array run one frame ahead without a bubble.
  assign in_ready  = rst_n && ((state == IDLE) || (final_beat && out_ready));
  assign capture   = in_valid && in_ready;

  always_comb begin
    out_data = '0;
    out_lane = 4'd0;
    if (state == DRAIN) begin
      out_data = shadow[lane_idx];
      out_lane = {1'b0, lane_idx};
    end
`ifdef MAC_DRAIN_SUM_EN
    else if (state == SUM) begin
      out_data = sum_q;
      out_lane = 4'd8;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lane_idx <= 3'd0;
      out_tag  <= '0;
    end else begin
      if (fire && final_beat) begin
        out_tag <= out_tag + 1'b1;
      end
      if (capture) begin
        state    <= DRAIN;
        lane_idx <= 3'd0;
      end else if (fire) begin
        if (final_beat) begin
          state <= IDLE;
        end
`ifdef MAC_DRAIN_SUM_EN
        else if (lane_idx == 3'd7) begin
          state <= SUM;
        end
`endif
        else begin
          lane_idx <= lane_idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
      end
`ifdef MAC_DRAIN_SUM_EN
      sum_q <= '0;
`endif
    end else if (capture) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= lanes_in[i];
      end
`ifdef MAC_DRAIN_SUM_EN
      sum_q <= sum_sat;
`endif
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: directed frames checked every cycle against a queue-of-beats model,
// plus hand-computed literal expectations on the observed beat log.
module tb_mac_result_drain;

`ifdef MAC_DRAIN_SUM_EN
  localparam int BEATS  = 9;
  localparam bit SUM_EN = 1'b1;
`else
  localparam int BEATS  = 8;
  localparam bit SUM_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic [3:0]  lane;
    logic        last;
    logic [3:0]  tag;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] mac_in [8];
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_lane;
  logic        out_last;
  logic [3:0]  out_tag;

  beat_t       expq[$];
  beat_t       log_q[$];
  logic [3:0]  m_tag = 4'd0;
  int          pos_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  mac_result_drain #(.DATA_W(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mac_in0(mac_in[0]), .mac_in1(mac_in[1]), .mac_in2(mac_in[2]), .mac_in3(mac_in[3]),
    .mac_in4(mac_in[4]), .mac_in5(mac_in[5]), .mac_in6(mac_in[6]), .mac_in7(mac_in[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt++;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, pos_cnt, act, exp);
    end
  endtask

  // Each captured set becomes 8 lane beats (plus a saturated sum beat when enabled).
  function automatic void push_frame();
    int total = 0;
    for (int i = 0; i < 8; i++) begin
      expq.push_back('{data: mac_in[i], lane: 4'(i), last: (i == 7) && !SUM_EN, tag: m_tag, cyc: 0});
      total += int'(mac_in[i]);
    end
    if (SUM_EN) begin
      expq.push_back('{data: 16'((total > 65535) ? 65535 : total), lane: 4'd8, last: 1'b1,
                       tag: m_tag, cyc: 0});
    end
  endfunction

  always @(negedge rst_n) begin
    expq.delete();
    m_tag = 4'd0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      logic  had;
      logic  cap;
      beat_t b;
      had = (expq.size() != 0);
      cap = in_valid && (had ? (expq[0].last && out_ready) : 1'b1);
      if (had && out_ready) begin
        b = expq.pop_front();
        if (b.last) m_tag = m_tag + 4'd1;
      end
      if (cap) push_frame();
    end
  end

  // Per-cycle comparison against the model, and a log of every beat the DUT hands over.
  always @(negedge clk) begin
    logic  ev;
    logic  er;
    beat_t b;
    ev = (expq.size() != 0);
    b  = '{default: '0};
    if (ev) b = expq[0];
    er = rst_n && (ev ? (b.last && out_ready) : 1'b1);
    check_output("out_valid", out_valid, ev);
    check_output("in_ready", in_ready, er);
    if (ev) begin
      check_output("out_data", out_data, b.data);
      check_output("out_lane", out_lane, b.lane);
      check_output("out_last", out_last, b.last);
      check_output("out_tag", out_tag, b.tag);
    end
    if (!rst_n) begin
      check_output("reset out_data", out_data, 0);
      check_output("reset out_lane", out_lane, 0);
      check_output("reset out_last", out_last, 0);
      check_output("reset out_tag", out_tag, 0);
    end
    if (rst_n && out_valid && out_ready) begin
      log_q.push_back('{data: out_data, lane: out_lane, last: out_last, tag: out_tag, cyc: pos_cnt});
    end
  end

  task automatic apply_stimulus(input logic [15:0] v [8], output int cap_cyc);
    for (int i = 0; i < 8; i++) mac_in[i] = v[i];
    in_valid = 1'b1;
    cap_cyc = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        cap_cyc = pos_cnt;
        break;
      end
    end
    if (cap_cyc < 0) check_output("capture timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t;
    for (t = 0; t < 3000 && log_q.size() < n; t++) @(posedge clk);
    if (log_q.size() < n) check_output("beat timeout", log_q.size(), n);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lane(input logic [3:0] lane);
    for (int t = 0; t < 100 && !(out_valid && out_lane == lane); t++) begin
      @(posedge clk);
      #1;
    end
    check_output("reach lane", out_lane, lane);
  endtask

  initial begin
    logic [15:0] v [8];
    int          cap;

    for (int i = 0; i < 8; i++) mac_in[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset in_ready", in_ready, 0);
    check_output("reset out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("release in_ready", in_ready, 1);
    check_output("release out_valid", out_valid, 0);

    $display("[TB] basic frame");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) v[i] = 16'(2 * (i + 1));
    apply_stimulus(v, cap);
    wait_beats(BEATS);
    check_output("first beat latency", log_q[0].cyc, cap + 1);
    for (int i = 0; i < 8; i++) begin
      check_output("basic data", log_q[i].data, 2 * (i + 1));
      check_output("basic lane", log_q[i].lane, i);
      check_output("basic last", log_q[i].last, (i == 7) && !SUM_EN);
      check_output("basic tag", log_q[i].tag, 0);
    end
    if (SUM_EN) check_output("basic sum", log_q[8].data, 16'h0048);

    $display("[TB] stall at lane 3");
    log_q.delete();
    for (int i = 0; i < 8; i++) v[i] = 16'(16 * (i + 1));
    apply_stimulus(v, cap);
    wait_lane(4'd3);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("stall lane", out_lane, 3);
      check_output("stall data", out_data, 16'h0040);
      check_output("stall tag", out_tag, 1);
      check_output("stall valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_beats(BEATS);
    check_output("stall beat count", log_q.size(), BEATS);
    for (int i = 0; i < BEATS; i++) check_output("stall lane order", log_q[i].lane, i);

    $display("[TB] back-to-back");
    log_q.delete();
    for (int i = 0; i < 8; i++) v[i] = 16'(16'h0101 * (i + 1));
    apply_stimulus(v, cap);
    for (int i = 0; i < 8; i++) v[i] = 16'(16'h1111 * (i + 1));
    apply_stimulus(v, cap);
    wait_beats(2 * BEATS);
    check_output("b2b prev last", log_q[BEATS-1].last, 1);
    check_output("b2b prev tag", log_q[BEATS-1].tag, 2);
    check_output("b2b lane0 data", log_q[BEATS].data, 16'h1111);
    check_output("b2b lane0 tag", log_q[BEATS].tag, 3);
    check_output("b2b no bubble", log_q[BEATS].cyc, log_q[BEATS-1].cyc + 1);

`ifdef MAC_DRAIN_SUM_EN
    $display("[TB] saturation");
    log_q.delete();
    for (int i = 0; i < 8; i++) v[i] = 16'hFFFF;
    apply_stimulus(v, cap);
    for (int i = 0; i < 8; i++) v[i] = 16'h2000;
    apply_stimulus(v, cap);
    for (int i = 0; i < 8; i++) v[i] = 16'h1000;
    apply_stimulus(v, cap);
    wait_beats(3 * BEATS);
    check_output("sat ffff", log_q[8].data, 16'hFFFF);
    check_output("sat 2000", log_q[17].data, 16'hFFFF);
    check_output("sat 1000", log_q[26].data, 16'h8000);
    check_output("sat lane", log_q[26].lane, 8);
`endif

    $display("[TB] tag wrap");
    rst_n = 1'b0;
    #1;
    check_output("wrap reset tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 8; i++) v[i] = 16'(k * 16 + i);
      apply_stimulus(v, cap);
    end
    wait_beats(17 * BEATS);
    for (int k = 0; k < 17; k++) begin
      check_output("wrap tag", log_q[k*BEATS].tag, k % 16);
      check_output("wrap data", log_q[k*BEATS].data, k * 16);
    end

    $display("[TB] mid-frame reset");
    for (int i = 0; i < 8; i++) v[i] = 16'(16'h0A00 + i);
    apply_stimulus(v, cap);
    wait_lane(4'd5);
    rst_n = 1'b0;
    #1;
    check_output("midreset out_valid", out_valid, 0);
    check_output("midreset out_tag", out_tag, 0);
    check_output("midreset in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    for (int i = 0; i < 8; i++) v[i] = 16'(16'h0B00 + i);
    apply_stimulus(v, cap);
    wait_beats(BEATS);
    repeat (4) @(posedge clk);
    #1;
    check_output("post reset count", log_q.size(), BEATS);
    check_output("post reset lane", log_q[0].lane, 0);
    check_output("post reset data", log_q[0].data, 16'h0B00);
    check_output("post reset tag", log_q[0].tag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
